// File: rtl/comparator_sort_ctrl.sv
// Burst bubble-sort engine: load up to DEPTH words, sort in place, stream out ascending.
// Optional SORT_EARLY_EXIT_EN ends the sort after the first pass with no swap.
module comparator_sort_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        UNLOAD
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    n_q;
    logic [CW-1:0]    p_q;
    logic [AW-1:0]    i_q;
    logic [AW-1:0]    k_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             busy_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
`ifdef SORT_EARLY_EXIT_EN
    logic             swapped_q;
`endif

    logic [AW-1:0]    ip1;
    logic [AW-1:0]    k_nxt;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             a_bigger;
    logic             accept;
    logic             close;
    logic             swap;
    logic             pass_end;
    logic             sort_done;
    logic [CW-1:0]    n_inc;
    logic [CW-1:0]    pass_last;

    assign ip1       = i_q + AW'(1);
    assign k_nxt     = k_q + AW'(1);
    assign cmp_a     = mem_q[i_q];
    assign cmp_b     = mem_q[ip1];
    assign a_bigger  = cmp_a > cmp_b;
    assign accept    = (state_q == LOAD) && in_valid && in_ready_q;
    assign n_inc     = n_q + CW'(1);
    assign close     = accept && (in_last || (n_inc == CW'(DEPTH)));
    assign swap      = (state_q == SORT) && a_bigger;
    assign pass_last = n_q - CW'(2) - p_q;
    assign pass_end  = (CW'(i_q) == pass_last);

`ifdef SORT_EARLY_EXIT_EN
    assign sort_done = pass_end &&
                       ((p_q == n_q - CW'(2)) || !(swapped_q || a_bigger));
`else
    assign sort_done = pass_end && (p_q == n_q - CW'(2));
`endif

    // Buffer has no reset: its contents are only read after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[n_q[AW-1:0]] <= in_data;
        end else if (swap) begin
            mem_q[i_q] <= cmp_b;
            mem_q[ip1] <= cmp_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            n_q         <= '0;
            p_q         <= '0;
            i_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                LOAD: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        n_q <= n_inc;
                        if (close) begin
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            p_q        <= '0;
                            i_q        <= '0;
`ifdef SORT_EARLY_EXIT_EN
                            swapped_q  <= 1'b0;
`endif
                            state_q    <= (n_inc == CW'(1)) ? UNLOAD : SORT;
                        end
                    end
                end
                SORT: begin
`ifdef SORT_EARLY_EXIT_EN
                    swapped_q <= pass_end ? 1'b0 : (swapped_q | a_bigger);
`endif
                    if (sort_done) begin
                        state_q <= UNLOAD;
                    end else if (pass_end) begin
                        p_q <= p_q + CW'(1);
                        i_q <= '0;
                    end else begin
                        i_q <= ip1;
                    end
                end
                UNLOAD: begin
                    // First UNLOAD cycle primes the output register.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= mem_q[0];
                        out_last_q  <= (n_q == CW'(1));
                        k_q         <= '0;
                    end else if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            n_q         <= '0;
                            busy_q      <= 1'b0;
                            state_q     <= LOAD;
                        end else begin
                            k_q        <= k_nxt;
                            out_data_q <= mem_q[k_nxt];
                            out_last_q <= (CW'(k_nxt) == n_q - CW'(1));
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
